// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the fetch stage
//   (instruction reads) and the memory stage (loads/stores). One access is in
//   flight at a time and moves through IDLE -> WAIT -> RESP. Data accesses win
//   over fetch unless fetch has been passed over STARVE_MAX times in a row.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   InstrReqF/InstrAddrF       fetch request (held until InstrValidF)
//   InstrRdataF/InstrValidF    registered fetch data, one-cycle completion pulse
//   StallF                     fetch stall (request pending, not completing)
//   DataReqM/DataWeM/...       data request, 1 = store, 0 = load
//   DataRdataM/DataValidM      registered load data, one-cycle completion pulse
//   StallM                     memory-stage stall
//   MemReq/MemWe/MemAddr/...   one-cycle issue strobe and fields to memory
//   MemRdata                   read data, valid MEM_LAT cycles after issue
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstrReqF,
  input  logic [ADDR_W-1:0] InstrAddrF,
  output logic [DATA_W-1:0] InstrRdataF,
  output logic              InstrValidF,
  output logic              StallF,
  input  logic              DataReqM,
  input  logic              DataWeM,
  input  logic [ADDR_W-1:0] DataAddrM,
  input  logic [DATA_W-1:0] DataWdataM,
  output logic [DATA_W-1:0] DataRdataM,
  output logic              DataValidM,
  output logic              StallM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;        // 0 = fetch, 1 = data
  logic                  r_we;           // in-flight access is a store
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic [DATA_W-1:0]     r_instr_rdata;
  logic [DATA_W-1:0]     r_data_rdata;

  logic w_elig_f;
  logic w_elig_d;
  logic w_starved;
  logic w_grant_f;
  logic w_grant_d;
  logic w_capture;

  // In RESP the requester just served still shows its old request, so only
  // the other one may issue. Grants are held off while reset is asserted so
  // MemReq stays low during reset.
  assign w_elig_f = reset & InstrReqF &
                    ((r_state == S_IDLE) || ((r_state == S_RESP) && r_owner));
  assign w_elig_d = reset & DataReqM &
                    ((r_state == S_IDLE) || ((r_state == S_RESP) && !r_owner));

  assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_MAX));
  assign w_grant_d = w_elig_d & (~w_elig_f | ~w_starved);
  assign w_grant_f = w_elig_f & ~w_grant_d;

  // Last WAIT cycle: memory data is valid now and is registered at this edge.
  assign w_capture = (r_state == S_WAIT) && (r_lat_cnt == LAT_W'(1));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: reset clears the read-data registers too, so a response that
      // was in flight when reset hit can never surface afterwards.
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_we          <= 1'b0;
      r_lat_cnt     <= '0;
      r_starve_cnt  <= '0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant_f || w_grant_d) begin
        r_owner   <= w_grant_d;
        r_we      <= w_grant_d & DataWeM;
        r_lat_cnt <= LAT_W'(MEM_LAT);
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if (w_grant_f) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && InstrReqF && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end

      // Stores complete without touching the load-data register.
      if (w_capture && !r_we) begin
        if (r_owner) r_data_rdata  <= MemRdata;
        else         r_instr_rdata <= MemRdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: w_state_nxt = (w_grant_f || w_grant_d) ? S_WAIT : S_IDLE;
      S_WAIT:         if (w_capture) w_state_nxt = S_RESP;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    MemReq   = w_grant_f | w_grant_d;
    MemWe    = w_grant_d & DataWeM;
    MemAddr  = '0;
    MemWdata = '0;
    if (w_grant_d) begin
      MemAddr  = DataAddrM;
      MemWdata = DataWdataM;
    end else if (w_grant_f) begin
      MemAddr  = InstrAddrF;
    end
    InstrValidF = (r_state == S_RESP) && !r_owner;
    DataValidM  = (r_state == S_RESP) &&  r_owner;
    StallF      = InstrReqF & ~InstrValidF;
    StallM      = DataReqM  & ~DataValidM;
  end

  assign InstrRdataF = r_instr_rdata;
  assign DataRdataM  = r_data_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LAT = 2, STARVE_MAX = 4).
// Inputs are driven 2 time units after the rising edge and outputs sampled
// 1 unit later, both well away from the clock edges.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              InstrReqF;
  logic [ADDR_W-1:0] InstrAddrF;
  logic [DATA_W-1:0] InstrRdataF;
  logic              InstrValidF;
  logic              StallF;
  logic              DataReqM;
  logic              DataWeM;
  logic [ADDR_W-1:0] DataAddrM;
  logic [DATA_W-1:0] DataWdataM;
  logic [DATA_W-1:0] DataRdataM;
  logic              DataValidM;
  logic              StallM;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .InstrReqF(InstrReqF), .InstrAddrF(InstrAddrF), .InstrRdataF(InstrRdataF),
    .InstrValidF(InstrValidF), .StallF(StallF),
    .DataReqM(DataReqM), .DataWeM(DataWeM), .DataAddrM(DataAddrM),
    .DataWdataM(DataWdataM), .DataRdataM(DataRdataM), .DataValidM(DataValidM),
    .StallM(StallM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata)
  );

  always #5 clk = ~clk;

  // Memory model: fixed contents per address until written; read data
  // appears exactly MEM_LAT (= 2) cycles after the issue cycle, junk otherwise.
  logic [DATA_W-1:0] wr_mem   [0:255];
  logic              wr_valid [0:255];
  logic [DATA_W-1:0] rd_d1 = '0;
  logic [DATA_W-1:0] rd_d2 = '0;

  initial for (int i = 0; i < 256; i++) wr_valid[i] = 1'b0;

  function automatic logic [DATA_W-1:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hE3A0_0001;
      8'h20:   return 32'h1234_5678;
      8'h30:   return 32'hA5A5_0001;
      8'h40:   return 32'h0000_0011;
      8'h44:   return 32'h0000_0077;
      8'h48:   return 32'hCAFE_0048;
      default: return {24'h5A5A5A, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (MemReq && MemWe) begin
      wr_mem[MemAddr[7:0]]   <= MemWdata;
      wr_valid[MemAddr[7:0]] <= 1'b1;
    end
    if (MemReq && !MemWe)
      rd_d1 <= wr_valid[MemAddr[7:0]] ? wr_mem[MemAddr[7:0]] : init_word(MemAddr[7:0]);
    else
      rd_d1 <= 32'hDEAD_BEEF;
    rd_d2 <= rd_d1;
  end
  assign MemRdata = rd_d2;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    InstrReqF  = 1'b0;
    InstrAddrF = '0;
    DataReqM   = 1'b0;
    DataWeM    = 1'b0;
    DataAddrM  = '0;
    DataWdataM = '0;
  endtask

  // Leaves the bench in the first cycle after reset release (state IDLE).
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    #1;
    n_checks++; if ({MemReq, MemWe, InstrValidF, DataValidM, StallF, StallM} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000",
        {MemReq, MemWe, InstrValidF, DataValidM, StallF, StallM}); end
    n_checks++; if (InstrRdataF !== 32'h0) begin
      n_fail++; $display("FAIL reset_irdata got=%h exp=0", InstrRdataF); end
    n_checks++; if (DataRdataM !== 32'h0) begin
      n_fail++; $display("FAIL reset_drdata got=%h exp=0", DataRdataM); end
    n_checks++; if (MemAddr !== 32'h0 || MemWdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_memfields got=%h/%h exp=0/0", MemAddr, MemWdata); end
    reset = 1'b1;
  endtask

  task automatic test_fetch_only();
    apply_reset();
    InstrReqF = 1'b1; InstrAddrF = 32'h10; #1;   // T, first cycle after release
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h10 && MemWe === 1'b0)) begin
      n_fail++; $display("FAIL fetch_issue got req=%b addr=%h we=%b exp 1/10/0", MemReq, MemAddr, MemWe); end
    n_checks++; if (StallF !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_T got=%b exp=1", StallF); end
    for (int c = 1; c <= 2; c++) begin
      step(); #1;                                 // T+1, T+2
      n_checks++; if (!(StallF === 1'b1 && InstrValidF === 1'b0 && MemReq === 1'b0)) begin
        n_fail++; $display("FAIL fetch_wait%0d got stall=%b valid=%b req=%b exp 1/0/0",
          c, StallF, InstrValidF, MemReq); end
    end
    step(); #1;                                   // T+3
    n_checks++; if (!(InstrValidF === 1'b1 && StallF === 1'b0)) begin
      n_fail++; $display("FAIL fetch_valid got valid=%b stall=%b exp 1/0", InstrValidF, StallF); end
    n_checks++; if (InstrRdataF !== 32'hE3A0_0001) begin
      n_fail++; $display("FAIL fetch_rdata got=%h exp=e3a00001", InstrRdataF); end
    n_checks++; if (MemReq !== 1'b0) begin
      n_fail++; $display("FAIL fetch_no_reissue got=%b exp=0", MemReq); end
    step(); InstrReqF = 1'b0; #1;                 // T+4
    n_checks++; if (!(InstrValidF === 1'b0 && InstrRdataF === 32'hE3A0_0001)) begin
      n_fail++; $display("FAIL fetch_hold got valid=%b rdata=%h exp 0/e3a00001", InstrValidF, InstrRdataF); end
  endtask

  task automatic test_priority();
    apply_reset();
    InstrReqF = 1'b1; InstrAddrF = 32'h20;
    DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h80; DataWdataM = 32'h55; #1;
    n_checks++; if (!(MemReq === 1'b1 && MemWe === 1'b1 && MemAddr === 32'h80 && MemWdata === 32'h55)) begin
      n_fail++; $display("FAIL prio_data_first got req=%b we=%b addr=%h wd=%h exp 1/1/80/55",
        MemReq, MemWe, MemAddr, MemWdata); end
    step(); step(); step(); #1;                   // T+3
    n_checks++; if (!(DataValidM === 1'b1 && StallM === 1'b0 && StallF === 1'b1)) begin
      n_fail++; $display("FAIL prio_store_valid got v=%b sm=%b sf=%b exp 1/0/1", DataValidM, StallM, StallF); end
    n_checks++; if (!(MemReq === 1'b1 && MemWe === 1'b0 && MemAddr === 32'h20 && MemWdata === 32'h0)) begin
      n_fail++; $display("FAIL prio_fetch_in_resp got req=%b we=%b addr=%h wd=%h exp 1/0/20/0",
        MemReq, MemWe, MemAddr, MemWdata); end
    n_checks++; if (DataRdataM !== 32'h0) begin
      n_fail++; $display("FAIL prio_store_rdata got=%h exp=0", DataRdataM); end
    step(); DataReqM = 1'b0; step(); step(); #1;  // T+6
    n_checks++; if (!(InstrValidF === 1'b1 && InstrRdataF === 32'h1234_5678)) begin
      n_fail++; $display("FAIL prio_fetch_valid got v=%b rd=%h exp 1/12345678", InstrValidF, InstrRdataF); end
    idle_inputs();
  endtask

  // Fetch is raised only in the IDLE cycles, so the RESP slot never hands it a
  // grant; every data grant with fetch pending advances the starvation count.
  task automatic test_starvation();
    apply_reset();
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h90; InstrAddrF = 32'h30;
    for (int g = 0; g < STARVE_MAX; g++) begin
      InstrReqF = 1'b1; #1;
      n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h90)) begin
        n_fail++; $display("FAIL starve_data_grant%0d got req=%b addr=%h exp 1/90", g, MemReq, MemAddr); end
      step(); InstrReqF = 1'b0; step(); step(); #1;
      n_checks++; if (DataValidM !== 1'b1) begin
        n_fail++; $display("FAIL starve_data_valid%0d got=%b exp=1", g, DataValidM); end
      step();
    end
    InstrReqF = 1'b1; #1;
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h30 && MemWe === 1'b0)) begin
      n_fail++; $display("FAIL starve_fetch_forced got req=%b addr=%h we=%b exp 1/30/0", MemReq, MemAddr, MemWe); end
    step(); step(); step(); #1;
    n_checks++; if (!(InstrValidF === 1'b1 && InstrRdataF === 32'hA5A5_0001)) begin
      n_fail++; $display("FAIL starve_fetch_valid got v=%b rd=%h exp 1/a5a50001", InstrValidF, InstrRdataF); end
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h90)) begin
      n_fail++; $display("FAIL starve_data_after got req=%b addr=%h exp 1/90", MemReq, MemAddr); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    InstrReqF = 1'b1; InstrAddrF = 32'h20;
    step(); step(); step();
    step(); InstrReqF = 1'b0;
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h44; #1;
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h44 && InstrRdataF === 32'h1234_5678)) begin
      n_fail++; $display("FAIL rstmid_load_issue got req=%b addr=%h ird=%h exp 1/44/12345678",
        MemReq, MemAddr, InstrRdataF); end
    step(); reset = 1'b0; idle_inputs();          // WAIT cycle of the load
    step(); #1;
    n_checks++; if ({MemReq, InstrValidF, DataValidM, StallF, StallM} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl got=%b exp=00000",
        {MemReq, InstrValidF, DataValidM, StallF, StallM}); end
    n_checks++; if (!(InstrRdataF === 32'h0 && DataRdataM === 32'h0)) begin
      n_fail++; $display("FAIL rstmid_rdata got=%h/%h exp 0/0", InstrRdataF, DataRdataM); end
    step(); #1;                                   // cycle the load would have responded in
    n_checks++; if (DataValidM !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_valid got=%b exp=0", DataValidM); end
    reset = 1'b1; InstrReqF = 1'b1; InstrAddrF = 32'h10; #1;
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h10)) begin
      n_fail++; $display("FAIL rstmid_first_grant got req=%b addr=%h exp 1/10", MemReq, MemAddr); end
    step(); step(); step(); #1;
    n_checks++; if (!(InstrValidF === 1'b1 && InstrRdataF === 32'hE3A0_0001 && DataRdataM === 32'h0)) begin
      n_fail++; $display("FAIL rstmid_fetch_done got v=%b ird=%h drd=%h exp 1/e3a00001/0",
        InstrValidF, InstrRdataF, DataRdataM); end
    idle_inputs();
  endtask

  task automatic test_drop_mid_access();
    apply_reset();
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h48; #1;
    n_checks++; if (!(MemReq === 1'b1 && MemAddr === 32'h48)) begin
      n_fail++; $display("FAIL drop_issue got req=%b addr=%h exp 1/48", MemReq, MemAddr); end
    step(); DataReqM = 1'b0; #1;                  // T+1
    n_checks++; if (!(MemReq === 1'b0 && StallM === 1'b0)) begin
      n_fail++; $display("FAIL drop_wait got req=%b stall=%b exp 0/0", MemReq, StallM); end
    step(); step(); #1;                           // T+3
    n_checks++; if (!(DataValidM === 1'b1 && DataRdataM === 32'hCAFE_0048)) begin
      n_fail++; $display("FAIL drop_valid got v=%b rd=%h exp 1/cafe0048", DataValidM, DataRdataM); end
    for (int c = 4; c <= 5; c++) begin
      step(); #1;
      n_checks++; if (!(DataValidM === 1'b0 && MemReq === 1'b0)) begin
        n_fail++; $display("FAIL drop_quiet_T%0d got v=%b req=%b exp 0/0", c, DataValidM, MemReq); end
    end
  endtask

  task automatic test_back_to_back_store_load();
    apply_reset();
    DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h40; #1;   // load old value
    step(); step(); step(); #1;
    n_checks++; if (!(DataValidM === 1'b1 && DataRdataM === 32'h11)) begin
      n_fail++; $display("FAIL b2b_load0 got v=%b rd=%h exp 1/11", DataValidM, DataRdataM); end
    step(); DataWeM = 1'b1; DataWdataM = 32'hAB; #1;           // store, same requester
    n_checks++; if (!(MemReq === 1'b1 && MemWe === 1'b1 && MemAddr === 32'h40 && MemWdata === 32'hAB)) begin
      n_fail++; $display("FAIL b2b_store_issue got req=%b we=%b addr=%h wd=%h exp 1/1/40/ab",
        MemReq, MemWe, MemAddr, MemWdata); end
    step(); step(); step(); #1;
    n_checks++; if (!(DataValidM === 1'b1 && DataRdataM === 32'h11)) begin
      n_fail++; $display("FAIL b2b_store_valid got v=%b rd=%h exp 1/11", DataValidM, DataRdataM); end
    step(); DataWeM = 1'b0; DataWdataM = 32'h0; #1;            // load back
    n_checks++; if (!(MemReq === 1'b1 && MemWe === 1'b0)) begin
      n_fail++; $display("FAIL b2b_load_issue got req=%b we=%b exp 1/0", MemReq, MemWe); end
    step(); step(); step(); #1;
    n_checks++; if (!(DataValidM === 1'b1 && DataRdataM === 32'hAB)) begin
      n_fail++; $display("FAIL b2b_load_valid got v=%b rd=%h exp 1/ab", DataValidM, DataRdataM); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_reset_mid_access();
    test_drop_mid_access();
    test_back_to_back_store_load();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
